data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU execute stage and a debug/DMA port:
// round-robin arbitration, bounded debug lock, and a two-slot read-return pipeline.
//
// state    | meaning
// ARB      | round-robin between cpu and dbg, lock counter held at 0
// DBG_LOCK | dbg owns the memory back-to-back, cpu held off
// RELEASE  | lock limit hit with cpu waiting; cpu gets one forced grant
module data_mem_arbiter #(
  parameter int A_SIZE   = 10,
  parameter int D_SIZE   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [A_SIZE-1:0] cpu_addr,
  input  logic [D_SIZE-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [D_SIZE-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [A_SIZE-1:0] dbg_addr,
  input  logic [D_SIZE-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [D_SIZE-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [A_SIZE-1:0] mem_addr,
  output logic [D_SIZE-1:0] mem_wdata,
  input  logic [D_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] LOCK_ONE = CW'(1);

  typedef enum logic [1:0] {ARB = 2'd0, DBG_LOCK = 2'd1, RELEASE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic              last_gnt_q, last_gnt_d;   // 1 = dbg was granted most recently
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [A_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [D_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_dbg_q, rd_dbg_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [D_SIZE-1:0] cpu_hold_q, cpu_hold_d;
  logic [D_SIZE-1:0] dbg_hold_q, dbg_hold_d;
  logic              any_gnt;

  always_comb begin : arb_fsm
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    case (state_q)
      ARB: begin
        lock_cnt_d = '0;
        if (cpu_req && (!dbg_req || last_gnt_q)) begin
          cpu_gnt = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt = 1'b1;
          if (dbg_lock) begin
            // the grant that takes the lock is the first of the locked run
            lock_cnt_d = LOCK_ONE;
            state_d    = ((LOCK_ONE == LOCK_MAX) && cpu_req) ? RELEASE : DBG_LOCK;
          end
        end
      end
      DBG_LOCK: begin
        if (!dbg_req || !dbg_lock) begin
          dbg_gnt    = dbg_req;
          lock_cnt_d = '0;
          state_d    = ARB;
        end else begin
          dbg_gnt = 1'b1;
          if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LOCK_ONE;
          if ((lock_cnt_d == LOCK_MAX) && cpu_req) state_d = RELEASE;
        end
      end
      RELEASE: begin
        cpu_gnt    = cpu_req;
        lock_cnt_d = '0;
        state_d    = ARB;
      end
      default: begin
        lock_cnt_d = '0;
        state_d    = ARB;
      end
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_comb begin : datapath
    any_gnt     = cpu_gnt | dbg_gnt;
    last_gnt_d  = dbg_gnt ? 1'b1 : (cpu_gnt ? 1'b0 : last_gnt_q);
    mem_en_d    = any_gnt;
    mem_we_d    = dbg_gnt ? dbg_we : (cpu_gnt & cpu_we);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_dbg_d    = rd_dbg_q;
    if (any_gnt) begin
      mem_addr_d  = dbg_gnt ? dbg_addr : cpu_addr;
      mem_wdata_d = dbg_gnt ? dbg_wdata : cpu_wdata;
      rd_dbg_d    = dbg_gnt;
    end
    // owner travels with the command so alternating reads return to the right port
    cpu_rvalid_d = mem_en_q & ~mem_we_q & ~rd_dbg_q;
    dbg_rvalid_d = mem_en_q & ~mem_we_q & rd_dbg_q;
    cpu_hold_d   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
    dbg_hold_d   = dbg_rvalid_q ? mem_rdata : dbg_hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      last_gnt_q   <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_dbg_q     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_hold_q   <= '0;
      dbg_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_gnt_q   <= last_gnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_dbg_q     <= rd_dbg_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_hold_q   <= cpu_hold_d;
      dbg_hold_q   <= dbg_hold_d;
    end
  end

  // read data is live from memory in the return cycle, then held
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
  assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_hold_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// run-length model of the arbitration rules and a behavioural synchronous RAM.
module tb_data_mem_arbiter;
  localparam int A  = 10;
  localparam int D  = 32;
  localparam int ML = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [A-1:0] cpu_addr, dbg_addr;
  logic [D-1:0] cpu_wdata, dbg_wdata;
  logic         cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [D-1:0] cpu_rdata, dbg_rdata;
  logic         mem_en, mem_we;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.A_SIZE(A), .D_SIZE(D), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [D-1:0] ram_init(input logic [A-1:0] a);
    return (a == 10'h005) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
  endfunction

  // synchronous RAM: read data appears the cycle after a read command, junk otherwise
  bit           ram_wr  [1024];
  logic [D-1:0] ram_val [1024];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram_wr[mem_addr]  <= 1'b1;
      ram_val[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? (ram_wr[mem_addr] ? ram_val[mem_addr] : ram_init(mem_addr))
                                     : $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); end
    n_cmp++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_err++; $display("FAIL rst_mem_en_we: got %b want 00", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL rst_mem_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_cmp++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, dbg_rvalid}); end
    n_cmp++; if (cpu_rdata !== '0 || dbg_rdata !== '0) begin n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
    tick();
    reset = 0;
    idle();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_addr = 10'h005;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b100) begin n_err++; $display("FAIL rd_gnt: got %b want 100", {cpu_gnt, dbg_gnt, cpu_stall}); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'h005) begin n_err++; $display("FAIL rd_mem_cmd: got en/we %b addr %h want 10 005", {mem_en, mem_we}, mem_addr); end
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid: got %b%b want 10", cpu_rvalid, dbg_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", cpu_rdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL rd_after: got rvalid %b mem_en %b want 0 0", cpu_rvalid, mem_en); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold: got %h want deadbeef", cpu_rdata); end
  endtask

  task automatic test_round_robin();
    logic [A-1:0] a;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        cpu_req = 1; cpu_addr = 10'(16 + i);
        dbg_req = 1; dbg_addr = 10'(32 + i);
      end
      @(negedge clk);
      if (i < 4) begin
        n_cmp++; if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_gnt[%0d]: got cpu %b dbg %b", i, cpu_gnt, dbg_gnt); end
        n_cmp++; if (cpu_stall !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_stall[%0d]: got %b want %b", i, cpu_stall, i % 2 == 1); end
      end
      if (i >= 2) begin
        n_cmp++; if (cpu_rvalid !== (i % 2 == 0) || dbg_rvalid !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_rvalid[%0d]: got cpu %b dbg %b", i, cpu_rvalid, dbg_rvalid); end
        if (i % 2 == 0) begin
          a = 10'(16 + i - 2);
          n_cmp++; if (cpu_rdata !== ram_init(a)) begin n_err++; $display("FAIL rr_cpu_rdata[%0d]: got %h want %h", i, cpu_rdata, ram_init(a)); end
        end else begin
          a = 10'(32 + i - 2);
          n_cmp++; if (dbg_rdata !== ram_init(a)) begin n_err++; $display("FAIL rr_dbg_rdata[%0d]: got %h want %h", i, dbg_rdata, ram_init(a)); end
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock_release();
    int nd = 0;
    int nc = 0;
    do_reset();
    cpu_req = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      cpu_req = 1; dbg_req = 1; dbg_lock = 1; dbg_addr = 10'(i);
      @(negedge clk);
      n_cmp++; if (dbg_gnt !== (i != 8) || cpu_gnt !== (i == 8)) begin n_err++; $display("FAIL lock_gnt[%0d]: got cpu %b dbg %b want cpu %b", i, cpu_gnt, dbg_gnt, i == 8); end
      n_cmp++; if (cpu_stall !== (i != 8)) begin n_err++; $display("FAIL lock_stall[%0d]: got %b want %b", i, cpu_stall, i != 8); end
      nd += int'(dbg_gnt);
      nc += int'(cpu_gnt);
      tick();
    end
    n_cmp++; if (nd != 11 || nc != 1) begin n_err++; $display("FAIL lock_totals: got dbg %0d cpu %0d want 11 1", nd, nc); end
    idle();
  endtask

  task automatic test_lock_exit();
    int e;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      idle();
      cpu_req  = (i >= 10 && i <= 14) || i >= 16;
      dbg_req  = (i <= 15);
      dbg_lock = !(i == 13 || i == 14);
      case (i)
        11, 14, 17: e = 1;
        16:         e = 0;
        default:    e = 2;
      endcase
      @(negedge clk);
      n_cmp++; if (cpu_gnt !== (e == 1) || dbg_gnt !== (e == 2)) begin n_err++; $display("FAIL lockx_gnt[%0d]: got cpu %b dbg %b want %0d", i, cpu_gnt, dbg_gnt, e); end
      if (i == 13 || i == 16) begin
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL lockx_stall[%0d]: got %b want 1", i, cpu_stall); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_dbg_write();
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h3FF; dbg_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, dbg_gnt} !== 2'b01) begin n_err++; $display("FAIL wr_gnt: got %b want 01", {cpu_gnt, dbg_gnt}); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 10'h3FF || mem_wdata !== 32'h12345678) begin
      n_err++; $display("FAIL wr_mem_cmd: got en/we %b addr %h data %h want 11 3ff 12345678", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    @(negedge clk);
    n_cmp++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 00", {cpu_rvalid, dbg_rvalid}); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    cpu_req = 1; cpu_addr = 10'h005;
    tick();
    idle();
    tick();
    tick();
    tick();
    cpu_req = 1; cpu_addr = 10'h006;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rif_gnt: got %b want 1", cpu_gnt); end
    tick();
    reset = 1;
    @(negedge clk);
    n_cmp++; if ({cpu_gnt, dbg_gnt} !== 2'b00) begin n_err++; $display("FAIL rif_gnt_in_reset: got %b want 00", {cpu_gnt, dbg_gnt}); end
    tick();
    reset = 0;
    idle();
    @(negedge clk);
    n_cmp++; if ({cpu_rvalid, dbg_rvalid, mem_en, mem_we} !== 4'b0000) begin n_err++; $display("FAIL rif_ctrl: got %b want 0000", {cpu_rvalid, dbg_rvalid, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL rif_mem: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_cmp++; if (cpu_rdata !== '0 || dbg_rdata !== '0) begin n_err++; $display("FAIL rif_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rif_rvalid2: got %b want 0", cpu_rvalid); end
  endtask

  // reference: m_run = length of the current locked dbg run (0 = arbitrating)
  int           m_run;
  bit           m_forced, m_last_dbg;
  bit           m_wr  [16];
  logic [D-1:0] m_val [16];
  bit           e1_en, e1_we, e1_dbg, e2_v, e2_dbg;
  logic [A-1:0] e1_addr;
  logic [D-1:0] e1_wdata, e1_data, e2_data, h_cpu, h_dbg;

  task automatic test_random();
    int           g;
    bit           rst, crv, drv;
    logic [A-1:0] ga;
    do_reset();
    m_run = 0; m_forced = 0; m_last_dbg = 1;
    e1_en = 0; e1_we = 0; e1_dbg = 0; e1_addr = '0; e1_wdata = '0; e1_data = '0;
    e2_v = 0; e2_dbg = 0; e2_data = '0; h_cpu = '0; h_dbg = '0;
    for (int k = 0; k < 16; k++) m_wr[k] = 0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      reset = rst;
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 10'($urandom_range(0, 15)); cpu_wdata = $urandom;
      dbg_req = 1'($urandom); dbg_we = 1'($urandom); dbg_addr = 10'($urandom_range(0, 15)); dbg_wdata = $urandom;
      dbg_lock = ($urandom_range(0, 3) != 0);
      if (rst) g = 0;
      else if (m_forced) g = cpu_req ? 1 : 0;
      else if (m_run > 0) g = dbg_req ? 2 : 0;
      else g = (cpu_req && (!dbg_req || m_last_dbg)) ? 1 : (dbg_req ? 2 : 0);
      crv = e2_v && !e2_dbg;
      drv = e2_v && e2_dbg;
      @(negedge clk);
      n_cmp++; if (cpu_gnt !== (g == 1) || dbg_gnt !== (g == 2)) begin n_err++; $display("FAIL rnd_gnt[%0d]: got cpu %b dbg %b want %0d", n, cpu_gnt, dbg_gnt, g); end
      n_cmp++; if (cpu_stall !== (cpu_req && g != 1)) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b", n, cpu_stall); end
      n_cmp++; if (mem_en !== e1_en) begin n_err++; $display("FAIL rnd_mem_en[%0d]: got %b want %b", n, mem_en, e1_en); end
      if (e1_en) begin
        n_cmp++; if (mem_we !== e1_we || mem_addr !== e1_addr || (e1_we && mem_wdata !== e1_wdata)) begin
          n_err++; $display("FAIL rnd_mem_cmd[%0d]: got we %b addr %h data %h want %b %h %h", n, mem_we, mem_addr, mem_wdata, e1_we, e1_addr, e1_wdata);
        end
      end
      n_cmp++; if (cpu_rvalid !== crv || dbg_rvalid !== drv) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", n, cpu_rvalid, dbg_rvalid, crv, drv); end
      n_cmp++; if (cpu_rdata !== (crv ? e2_data : h_cpu)) begin n_err++; $display("FAIL rnd_cpu_rdata[%0d]: got %h want %h", n, cpu_rdata, crv ? e2_data : h_cpu); end
      n_cmp++; if (dbg_rdata !== (drv ? e2_data : h_dbg)) begin n_err++; $display("FAIL rnd_dbg_rdata[%0d]: got %h want %h", n, dbg_rdata, drv ? e2_data : h_dbg); end
      if (rst) begin
        m_run = 0; m_forced = 0; m_last_dbg = 1;
        e1_en = 0; e2_v = 0; h_cpu = '0; h_dbg = '0;
      end else begin
        if (crv) h_cpu = e2_data;
        if (drv) h_dbg = e2_data;
        e2_v = e1_en && !e1_we; e2_dbg = e1_dbg; e2_data = e1_data;
        e1_en = (g != 0);
        if (g != 0) begin
          ga       = (g == 2) ? dbg_addr : cpu_addr;
          e1_we    = (g == 2) ? dbg_we : cpu_we;
          e1_wdata = (g == 2) ? dbg_wdata : cpu_wdata;
          e1_addr  = ga;
          e1_dbg   = (g == 2);
          e1_data  = m_wr[ga[3:0]] ? m_val[ga[3:0]] : ram_init(ga);
          if (e1_we) begin m_wr[ga[3:0]] = 1; m_val[ga[3:0]] = e1_wdata; end
        end
        if (m_forced) begin
          m_forced = 0; m_run = 0;
        end else if (m_run > 0) begin
          if (dbg_req && dbg_lock) begin
            m_run = (m_run < ML) ? m_run + 1 : ML;
            if (m_run == ML && cpu_req) m_forced = 1;
          end else m_run = 0;
        end else if (g == 2 && dbg_lock) begin
          m_run = 1;
          if (ML == 1 && cpu_req) m_forced = 1;
        end
        if (g != 0) m_last_dbg = (g == 2);
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    tick();
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_lock_release();
    test_lock_exit();
    test_dbg_write();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
